// File: rtl/soc_pio_pkg.sv
`timescale 1ns/1ps
// Shared constants and helpers for the soc_design PIO slaves.
// Register word addresses, edge/irq mode encodings and read-data zero extension.
package soc_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

  // Keeps only the low `width` bits so unused readdata bits always return 0.
  function automatic logic [31:0] zext32(input logic [31:0] value, input int width);
    logic [31:0] keep;
    keep = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return value & keep;
  endfunction

endpackage

// File: rtl/soc_pio_edge_sync.sv
`timescale 1ns/1ps
// Input synchroniser plus per-bit edge detector for the input PIO.
// data_sync lags in_port by SYNC_STAGES clocks; edge_pulse is combinational from data_sync/prev_sync.
module soc_pio_edge_sync
  import soc_pio_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] data_sync,
  output logic [DATA_WIDTH-1:0] edge_pulse
);

  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] prev_sync;
  logic [DATA_WIDTH-1:0] rise;
  logic [DATA_WIDTH-1:0] fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_sync <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_sync <= sync_q[SYNC_STAGES-1];
    end
  end

  assign data_sync = sync_q[SYNC_STAGES-1];

  // prev_sync resets to 0, so an input already high at reset release reports a rise.
  assign rise = data_sync & ~prev_sync;
  assign fall = ~data_sync & prev_sync;

  always_comb begin
    edge_pulse = rise;
    case (EDGE_TYPE)
      EDGE_FALL: edge_pulse = fall;
      EDGE_ANY:  edge_pulse = rise | fall;
      default:   edge_pulse = rise;
    endcase
  end

endmodule

// File: rtl/soc_design_pio_in_irq.sv
`timescale 1ns/1ps
// Avalon-MM input PIO with edge capture, per-bit irq mask and a registered level irq.
// Read latency 1 clock, irq registered 1 clock after source/mask; no waitrequest, never stalls.
module soc_design_pio_in_irq
  import soc_pio_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE,
  parameter int IRQ_TYPE    = IRQ_EDGE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  if (DATA_WIDTH < 1 || DATA_WIDTH > 32) begin : g_bad_width
    initial $error("soc_design_pio_in_irq: DATA_WIDTH %0d outside 1..32", DATA_WIDTH);
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    initial $error("soc_design_pio_in_irq: SYNC_STAGES %0d outside 2..4", SYNC_STAGES);
  end
  if (EDGE_TYPE < EDGE_RISE || EDGE_TYPE > EDGE_ANY) begin : g_bad_edge
    initial $error("soc_design_pio_in_irq: EDGE_TYPE %0d outside 0..2", EDGE_TYPE);
  end
  if (IRQ_TYPE != IRQ_LEVEL && IRQ_TYPE != IRQ_EDGE) begin : g_bad_irq
    initial $error("soc_design_pio_in_irq: IRQ_TYPE %0d outside 0..1", IRQ_TYPE);
  end

  logic [DATA_WIDTH-1:0] data_sync;
  logic [DATA_WIDTH-1:0] edge_pulse;
  logic [DATA_WIDTH-1:0] irqmask;
  logic [DATA_WIDTH-1:0] edgecap;
  logic [DATA_WIDTH-1:0] cap_clr;
  logic [DATA_WIDTH-1:0] irq_src;
  logic [31:0]           rd_mux;
  logic                  wr_en;
  logic                  unused_wdata;

  soc_pio_edge_sync #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_edge_sync (
    .clk        (clk),
    .reset      (reset),
    .in_port    (in_port),
    .data_sync  (data_sync),
    .edge_pulse (edge_pulse)
  );

  assign wr_en        = chipselect && !write_n;
  assign cap_clr      = (wr_en && address == PIO_ADDR_EDGECAP) ? writedata[DATA_WIDTH-1:0] : '0;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqmask <= '0;
    end else if (wr_en && address == PIO_ADDR_IRQMASK) begin
      irqmask <= writedata[DATA_WIDTH-1:0];
    end
  end

  // Edge OR-ed in after the clear, so a coincident new edge survives a W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edgecap <= '0;
    end else begin
      edgecap <= (edgecap & ~cap_clr) | edge_pulse;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      PIO_ADDR_DATA:    rd_mux[DATA_WIDTH-1:0] = data_sync;
      PIO_ADDR_IRQMASK: rd_mux[DATA_WIDTH-1:0] = irqmask;
      PIO_ADDR_EDGECAP: rd_mux[DATA_WIDTH-1:0] = edgecap;
      default:          rd_mux = '0;
    endcase
  end

  assign irq_src = (IRQ_TYPE == IRQ_LEVEL) ? data_sync : edgecap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= zext32(rd_mux, DATA_WIDTH);
      irq      <= |(irq_src & irqmask);
    end
  end

endmodule

// File: tb/tb_soc_design_pio_in_irq.sv
`timescale 1ns/1ps
// Randomised scoreboard bench for soc_design_pio_in_irq across three parameter sets.
// A spec-level model pushes expected readdata/irq per clock; a monitor pops and compares.
module tb_soc_design_pio_in_irq;
  import soc_pio_pkg::*;

  localparam int NI = 3;
  localparam int CW  [NI] = '{8, 32, 5};
  localparam int CST [NI] = '{2, 3, 4};
  localparam int CET [NI] = '{EDGE_RISE, EDGE_ANY, EDGE_FALL};
  localparam int CIT [NI] = '{IRQ_EDGE, IRQ_LEVEL, IRQ_EDGE};

  typedef struct packed {
    logic [NI-1:0][31:0] rd;
    logic [NI-1:0]       irq;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] in_bus = 32'd0;
  logic [31:0] rd  [NI];
  logic        irqv[NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  soc_design_pio_in_irq #(.DATA_WIDTH(CW[0]), .SYNC_STAGES(CST[0]), .EDGE_TYPE(CET[0]), .IRQ_TYPE(CIT[0])) dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_bus[7:0]), .readdata(rd[0]), .irq(irqv[0]));
  soc_design_pio_in_irq #(.DATA_WIDTH(CW[1]), .SYNC_STAGES(CST[1]), .EDGE_TYPE(CET[1]), .IRQ_TYPE(CIT[1])) dut1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_bus), .readdata(rd[1]), .irq(irqv[1]));
  soc_design_pio_in_irq #(.DATA_WIDTH(CW[2]), .SYNC_STAGES(CST[2]), .EDGE_TYPE(CET[2]), .IRQ_TYPE(CIT[2])) dut2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_bus[4:0]), .readdata(rd[2]), .irq(irqv[2]));

  function automatic logic [31:0] wmask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h", name, idx, $time, act, exp);
    end
  endtask

  // Reference model: DATA is the input value seen SYNC_STAGES clocks ago,
  // taken from a history of sampled inputs since the last reset.
  logic [31:0] m_sync [NI];
  logic [31:0] m_prev [NI];
  logic [31:0] m_mask [NI];
  logic [31:0] m_ecap [NI];
  logic [31:0] in_hist [$];
  exp_t        exp_q [$];

  always @(posedge clk or posedge reset) begin
    exp_t        e;
    logic [31:0] msk, rdv, edg;
    logic        wr;
    if (reset) begin
      for (int i = 0; i < NI; i++) begin
        m_sync[i] = '0; m_prev[i] = '0; m_mask[i] = '0; m_ecap[i] = '0;
      end
      in_hist.delete();
      exp_q.delete();
    end else begin
      e  = '0;
      wr = chipselect && !write_n;
      for (int i = 0; i < NI; i++) begin
        msk = wmask(CW[i]);
        case (address)
          2'd0:    rdv = m_sync[i];
          2'd1:    rdv = m_mask[i];
          2'd3:    rdv = m_ecap[i];
          default: rdv = 32'd0;
        endcase
        e.rd[i]  = rdv;
        e.irq[i] = |(((CIT[i] == IRQ_EDGE) ? m_ecap[i] : m_sync[i]) & m_mask[i]);
        if (CET[i] == EDGE_RISE)      edg = m_sync[i] & ~m_prev[i];
        else if (CET[i] == EDGE_FALL) edg = ~m_sync[i] & m_prev[i];
        else                          edg = m_sync[i] ^ m_prev[i];
        if (wr && address == 2'd3) m_ecap[i] = m_ecap[i] & ~(writedata & msk);
        m_ecap[i] = m_ecap[i] | edg;
        if (wr && address == 2'd1) m_mask[i] = writedata & msk;
        m_prev[i] = m_sync[i];
      end
      in_hist.push_back(in_bus);
      for (int i = 0; i < NI; i++) begin
        m_sync[i] = (in_hist.size() >= CST[i]) ? (in_hist[in_hist.size() - CST[i]] & wmask(CW[i])) : 32'd0;
      end
      if (in_hist.size() > 8) void'(in_hist.pop_front());
      exp_q.push_back(e);
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < NI; i++) begin
          chk("readdata", i, rd[i], e.rd[i]);
          chk("irq", i, {31'd0, irqv[i]}, {31'd0, e.irq[i]});
        end
      end
    end
  end

  // Drives one bus/input cycle; entered and left at posedge+2.
  task automatic cyc(input logic [1:0] a, input logic wr, input logic [31:0] wd, input logic [31:0] inp);
    address    = a;
    chipselect = wr;
    write_n    = !wr;
    writedata  = wd;
    in_bus     = inp;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n, input logic [1:0] a, input logic [31:0] inp);
    for (int k = 0; k < n; k++) cyc(a, 1'b0, 32'd0, inp);
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_readdata", i, rd[i], 32'd0);
      chk("rst_irq", i, {31'd0, irqv[i]}, 32'd0);
    end
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [31:0] inp;
    logic [1:0]  a;
    logic        wr;
    logic [31:0] wd;

    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #2;

    // Reset mid-stream with inputs high and masks set, then DATA recovers.
    cyc(2'd1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(6, 2'd3, 32'hFFFF_FFFF);
    pulse_reset();
    idle(3, 2'd1, 32'hFFFF_FFFF);
    idle(7, 2'd0, 32'hFFFF_FFFF);

    // Rising capture on bit 2 with mask 04, then fall.
    cyc(2'd3, 1'b1, 32'hFFFF_FFFF, 32'd0);
    idle(6, 2'd3, 32'd0);
    cyc(2'd3, 1'b1, 32'hFFFF_FFFF, 32'd0);
    cyc(2'd1, 1'b1, 32'h04, 32'd0);
    idle(7, 2'd3, 32'h04);
    idle(7, 2'd3, 32'h00);

    // W1C coinciding with a new bit-2 edge, then a plain clear.
    cyc(2'd3, 1'b1, 32'hFFFF_FFFF, 32'd0);
    cyc(2'd3, 1'b0, 32'd0, 32'h04);
    cyc(2'd3, 1'b0, 32'd0, 32'h04);
    cyc(2'd3, 1'b1, 32'h04, 32'h04);
    idle(3, 2'd3, 32'h04);
    cyc(2'd3, 1'b1, 32'h04, 32'h04);
    idle(3, 2'd3, 32'h04);

    // Level irq: mask 80 with input 81, then bit 7 falls.
    cyc(2'd1, 1'b1, 32'h00, 32'h81);
    idle(5, 2'd0, 32'h81);
    cyc(2'd1, 1'b1, 32'h80, 32'h81);
    idle(2, 2'd1, 32'h81);
    idle(7, 2'd0, 32'h01);

    // Bit 31 toggles with a clear between.
    cyc(2'd3, 1'b1, 32'hFFFF_FFFF, 32'h0);
    idle(6, 2'd3, 32'h8000_0000);
    cyc(2'd3, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000);
    idle(6, 2'd3, 32'h0);
    for (int k = 0; k < 4; k++) idle(1, k[1:0], 32'h0);

    // Writes that must be ignored, then mask readback.
    cyc(2'd1, 1'b1, 32'h0000_00A5, 32'h5A);
    cyc(2'd0, 1'b1, 32'hFFFF_FFFF, 32'h5A);
    cyc(2'd2, 1'b1, 32'hFFFF_FFFF, 32'h5A);
    address = 2'd1; chipselect = 1'b0; write_n = 1'b0; writedata = 32'hFFFF_FFFF;
    @(posedge clk);
    #2;
    for (int k = 0; k < 4; k++) idle(2, k[1:0], 32'h5A);

    // Randomised traffic with sparse input toggles and occasional resets.
    inp = 32'h5A;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(3) == 0) inp = inp ^ ($urandom & $urandom);
      a  = 2'($urandom_range(3));
      wr = ($urandom_range(3) == 0);
      wd = ($urandom_range(1) == 0) ? $urandom : ($urandom & $urandom);
      cyc(a, wr, wd, inp);
      if ($urandom_range(499) == 0) pulse_reset();
    end

    idle(3, 2'd0, inp);
    chk("scoreboard_drain", 0, exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
